// File: rtl/elev_pkg.sv
// Shared constants, state encoding and SCAN target helper for the
// four-floor elevator call arbiter.
package elev_pkg;

   localparam int NUM_FLOORS = 4;

   localparam logic [1:0] FLR_A = 2'd0;
   localparam logic [1:0] FLR_B = 2'd1;
   localparam logic [1:0] FLR_C = 2'd2;
   localparam logic [1:0] FLR_D = 2'd3;

   localparam logic UP   = 1'b0;
   localparam logic DOWN = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      DWELL = 1'b1
   } arb_state_e;

   // One-hot SCAN target; the current floor itself is never selected.
   function automatic logic [NUM_FLOORS-1:0] scanSelect(
      input logic [NUM_FLOORS-1:0] pend,
      input logic [1:0]            flr,
      input logic                  dir
   );
      logic [NUM_FLOORS-1:0] lowAbove;
      logic [NUM_FLOORS-1:0] highBelow;
      lowAbove  = '0;
      highBelow = '0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pend[i] && (i > int'(flr))) begin
            lowAbove = NUM_FLOORS'(1) << i;
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pend[i] && (i < int'(flr))) begin
            highBelow = NUM_FLOORS'(1) << i;
         end
      end
      if (dir == UP) begin
         scanSelect = (lowAbove != '0) ? lowAbove : highBelow;
      end else begin
         scanSelect = (highBelow != '0) ? highBelow : lowAbove;
      end
   endfunction

endpackage

// File: rtl/elev_btn_debounce.sv
// Per-button 2-flop synchronizer and debouncer producing a one-cycle
// pulse when the debounced level rises.
module elev_btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic rise_o
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic          stable_d;
   logic          rise_q;
   logic          rise_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The level only flips after DEB_CYCLES consecutive disagreeing samples.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise_d   = 1'b0;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
         cnt_d    = '0;
         stable_d = ~stable_q;
         rise_d   = ~stable_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/elev_call_arbiter.sv
// Latches debounced calls, presents one SCAN-ordered request to the
// controller and holds a served floor through a door dwell.
module elev_call_arbiter
   import elev_pkg::*;
#(
   parameter int DEB_CYCLES   = 16,
   parameter int DWELL_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn,
   input  logic [1:0] floor,
   input  logic       dir,
   output logic       ra,
   output logic       rb,
   output logic       rc,
   output logic       rd,
   output logic [3:0] pending,
   output logic       door_open
);

   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

   logic [NUM_FLOORS-1:0] rise;
   logic [NUM_FLOORS-1:0] pending_q;
   logic [NUM_FLOORS-1:0] pending_d;
   logic [NUM_FLOORS-1:0] req_q;
   logic [NUM_FLOORS-1:0] req_d;
   logic                  door_q;
   logic                  door_d;
   logic [DW-1:0]         dwell_q;
   logic [DW-1:0]         dwell_d;
   arb_state_e            state_q;
   arb_state_e            state_d;
   logic                  dwellDone;

   for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
      elev_btn_debounce #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .btn_i (btn[g]),
         .rise_o(rise[g])
      );
   end

   assign dwellDone = (state_q == DWELL) && (dwell_q == '0);

   // The dwell-end clear is applied after new latches so the clear wins.
   always_comb begin
      pending_d = pending_q | rise;
      if (dwellDone) begin
         pending_d[floor] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dwell_q   <= '0;
         pending_q <= '0;
         req_q     <= '0;
         door_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         pending_q <= pending_d;
         req_q     <= req_d;
         door_q    <= door_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      case (state_q)
         IDLE: begin
            if (pending_q[floor]) begin
               state_d = DWELL;
               dwell_d = DW'(DWELL_CYCLES - 1);
            end
         end
         DWELL: begin
            if (dwell_q == '0) begin
               state_d = IDLE;
            end else begin
               dwell_d = dwell_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed one cycle ahead and registered.
   always_comb begin
      req_d  = '0;
      door_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending_q[floor]) begin
               req_d[floor] = 1'b1;
               door_d       = 1'b1;
            end else if (pending_q != '0) begin
               req_d = scanSelect(pending_q, floor, dir);
            end
         end
         DWELL: begin
            if (!dwellDone) begin
               req_d[floor] = 1'b1;
               door_d       = 1'b1;
            end
         end
         default: begin
            req_d  = '0;
            door_d = 1'b0;
         end
      endcase
   end

   assign ra        = req_q[0];
   assign rb        = req_q[1];
   assign rc        = req_q[2];
   assign rd        = req_q[3];
   assign pending   = pending_q;
   assign door_open = door_q;

endmodule

// File: tb/tb_elev_call_arbiter.sv
// Scoreboard bench for elev_call_arbiter with DEB_CYCLES=4, DWELL_CYCLES=3:
// stimulus queues edge-tagged expectations, a monitor checks them on negedge.
module tb_elev_call_arbiter;
   import elev_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [3:0] btn;
   logic [1:0] floor;
   logic       dir;
   logic       ra;
   logic       rb;
   logic       rc;
   logic       rd;
   logic [3:0] pending;
   logic       door_open;

   typedef struct {
      int         edgeNo;
      string      name;
      logic [3:0] req;
      logic [3:0] pend;
      logic       door;
   } exp_t;

   exp_t expQ[$];
   int   edgeCnt    = 0;
   int   compared   = 0;
   int   mismatched = 0;
   int   b;
   int   widths[3]  = '{1, 2, 3};

   elev_call_arbiter #(
      .DEB_CYCLES  (4),
      .DWELL_CYCLES(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn      (btn),
      .floor    (floor),
      .dir      (dir),
      .ra       (ra),
      .rb       (rb),
      .rc       (rc),
      .rd       (rd),
      .pending  (pending),
      .door_open(door_open)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] btnV, input logic [1:0] floorV, input logic dirV);
      btn   = btnV;
      floor = floorV;
      dir   = dirV;
   endtask

   task automatic expectAt(input int e, input string name, input logic [3:0] req,
                           input logic [3:0] pend, input logic door);
      exp_t x;
      x.edgeNo = e;
      x.name   = name;
      x.req    = req;
      x.pend   = pend;
      x.door   = door;
      expQ.push_back(x);
   endtask

   task automatic checkOutput(input exp_t x);
      logic [3:0] reqNow;
      reqNow = {rd, rc, rb, ra};
      compared++;
      if (reqNow !== x.req) begin
         mismatched++;
         $display("[TB] FAIL %s req @edge %0d: got %b expected %b", x.name, x.edgeNo, reqNow, x.req);
      end
      compared++;
      if (pending !== x.pend) begin
         mismatched++;
         $display("[TB] FAIL %s pending @edge %0d: got %b expected %b", x.name, x.edgeNo, pending, x.pend);
      end
      compared++;
      if (door_open !== x.door) begin
         mismatched++;
         $display("[TB] FAIL %s door_open @edge %0d: got %b expected %b", x.name, x.edgeNo, door_open, x.door);
      end
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      applyStimulus(4'b0000, FLR_A, UP);
      step(2);
      expectAt(edgeCnt, "reset", 4'b0000, 4'b0000, 1'b0);
      rst_n = 1'b1;
      step(1);
   endtask

   // Monitor: request lines must never be more than one-hot, and any
   // expectation due at this edge is popped and compared.
   always @(negedge clk) begin
      exp_t x;
      compared++;
      if ($countones({rd, rc, rb, ra}) > 1) begin
         mismatched++;
         $display("[TB] FAIL onehot @edge %0d: got %b expected at most one bit", edgeCnt, {rd, rc, rb, ra});
      end
      while (expQ.size() > 0 && expQ[0].edgeNo <= edgeCnt) begin
         x = expQ.pop_front();
         if (x.edgeNo < edgeCnt) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s missed: due edge %0d, now edge %0d", x.name, x.edgeNo, edgeCnt);
         end else begin
            checkOutput(x);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(4'b0000, FLR_A, UP);

      // Test 1: latch floor 2, request rc, then dwell there and clear.
      resetDut();
      applyStimulus(4'b0100, FLR_A, UP);
      b = edgeCnt;
      expectAt(b + 6,  "t1_nolatch", 4'b0000, 4'b0000, 1'b0);
      expectAt(b + 7,  "t1_latch",   4'b0000, 4'b0100, 1'b0);
      expectAt(b + 8,  "t1_req",     4'b0100, 4'b0100, 1'b0);
      step(8);
      applyStimulus(4'b0000, FLR_C, UP);
      expectAt(b + 9,  "t1_dwell0",  4'b0100, 4'b0100, 1'b1);
      expectAt(b + 10, "t1_dwell1",  4'b0100, 4'b0100, 1'b1);
      expectAt(b + 11, "t1_dwell2",  4'b0100, 4'b0100, 1'b1);
      expectAt(b + 12, "t1_clear",   4'b0000, 4'b0000, 1'b0);
      expectAt(b + 13, "t1_idle",    4'b0000, 4'b0000, 1'b0);
      step(6);

      // Test 2: SCAN selection flips with direction.
      resetDut();
      applyStimulus(4'b1001, FLR_B, UP);
      b = edgeCnt;
      expectAt(b + 6,  "t2_nolatch", 4'b0000, 4'b0000, 1'b0);
      expectAt(b + 7,  "t2_latch",   4'b0000, 4'b1001, 1'b0);
      expectAt(b + 8,  "t2_up",      4'b1000, 4'b1001, 1'b0);
      step(8);
      applyStimulus(4'b0000, FLR_B, DOWN);
      expectAt(b + 9,  "t2_down",    4'b0001, 4'b1001, 1'b0);
      expectAt(b + 10, "t2_down_h",  4'b0001, 4'b1001, 1'b0);
      step(3);

      // Test 3: bouncing button never latches.
      resetDut();
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0010, FLR_A, UP);
            step(widths[k]);
            applyStimulus(4'b0000, FLR_A, UP);
            step(1);
            expectAt(edgeCnt, "t3_bounce", 4'b0000, 4'b0000, 1'b0);
         end
      end
      step(8);
      expectAt(edgeCnt, "t3_settled", 4'b0000, 4'b0000, 1'b0);
      step(1);

      // Test 4: call on the current floor goes straight to dwell.
      resetDut();
      applyStimulus(4'b1000, FLR_D, UP);
      b = edgeCnt;
      expectAt(b + 1,  "t4_idle",    4'b0000, 4'b0000, 1'b0);
      expectAt(b + 7,  "t4_latch",   4'b0000, 4'b1000, 1'b0);
      expectAt(b + 8,  "t4_dwell0",  4'b1000, 4'b1000, 1'b1);
      step(8);
      applyStimulus(4'b0000, FLR_D, UP);
      expectAt(b + 9,  "t4_dwell1",  4'b1000, 4'b1000, 1'b1);
      expectAt(b + 10, "t4_dwell2",  4'b1000, 4'b1000, 1'b1);
      expectAt(b + 11, "t4_clear",   4'b0000, 4'b0000, 1'b0);
      expectAt(b + 12, "t4_idle2",   4'b0000, 4'b0000, 1'b0);
      step(5);

      // Test 5: new latches land on the dwell-end edge; clear wins on floor 1.
      resetDut();
      applyStimulus(4'b0010, FLR_A, UP);
      b = edgeCnt;
      expectAt(b + 7,  "t5_latch",   4'b0000, 4'b0010, 1'b0);
      expectAt(b + 8,  "t5_req",     4'b0010, 4'b0010, 1'b0);
      step(5);
      applyStimulus(4'b0000, FLR_A, UP);
      step(7);
      applyStimulus(4'b1010, FLR_A, UP);
      step(3);
      applyStimulus(4'b1010, FLR_B, UP);
      expectAt(b + 15, "t5_hold",    4'b0010, 4'b0010, 1'b0);
      expectAt(b + 16, "t5_dwell0",  4'b0010, 4'b0010, 1'b1);
      expectAt(b + 17, "t5_dwell1",  4'b0010, 4'b0010, 1'b1);
      expectAt(b + 18, "t5_dwell2",  4'b0010, 4'b0010, 1'b1);
      expectAt(b + 19, "t5_clear",   4'b0000, 4'b1000, 1'b0);
      expectAt(b + 20, "t5_next",    4'b1000, 4'b1000, 1'b0);
      step(5);
      applyStimulus(4'b0000, FLR_B, UP);
      step(2);

      // Test 6: asynchronous reset in the middle of a dwell.
      resetDut();
      applyStimulus(4'b0100, FLR_C, UP);
      b = edgeCnt;
      expectAt(b + 8,  "t6_dwell",   4'b0100, 4'b0100, 1'b1);
      step(9);
      rst_n = 1'b0;
      applyStimulus(4'b0000, FLR_C, UP);
      expectAt(edgeCnt, "t6_async",   4'b0000, 4'b0000, 1'b0);
      step(1);
      expectAt(edgeCnt, "t6_held",    4'b0000, 4'b0000, 1'b0);
      rst_n = 1'b1;
      expectAt(edgeCnt + 2, "t6_release", 4'b0000, 4'b0000, 1'b0);
      step(3);

      step(2);
      while (expQ.size() > 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s unchecked: due edge %0d, now edge %0d", expQ[0].name, expQ[0].edgeNo, edgeCnt);
         void'(expQ.pop_front());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
